// File: rtl/qc_enc_pkg.sv
// Shared types and constants for the qc_encoder frame sequencer.
package qc_enc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam int DATA_W      = 27;
    localparam int CW_W        = 162;
    localparam int NUM_BLK_DEF = 18;

    // DRAIN spans ROM_LAT+ENC_LAT-1 cycles; the down-counter ends on zero.
    function automatic int drain_load(input int rom_lat, input int enc_lat);
        return rom_lat + enc_lat - 2;
    endfunction

endpackage

// File: rtl/qc_lat_pipe.sv
// Resettable, flushable shift register delaying a W-bit word by DEPTH cycles.
module qc_lat_pipe #(
    parameter int W     = 2,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    generate
        if (DEPTH < 1) begin : g_depth_chk
            $error("qc_lat_pipe: DEPTH must be at least 1");
        end

        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [W-1:0] w_in;
            logic [W-1:0] r_q;

            if (gi == 0) begin : g_head
                assign w_in = i_d;
            end else begin : g_tail
                assign w_in = g_stage[gi-1].r_q;
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_q <= '0;
                end else if (i_flush) begin
                    r_q <= '0;
                end else begin
                    r_q <= w_in;
                end
            end
        end
    endgenerate

    assign o_q = g_stage[DEPTH-1].r_q;

endmodule

// File: rtl/qc_enc_ctrl.sv
// Frame sequencer for qc_encoder: ROM fetch, encoder strobes, codeword handshake.
// Define QC_ENC_CTRL_BP_EN to hold cw_valid until cw_ready; otherwise cw_valid is a 1-cycle pulse.
module qc_enc_ctrl
    import qc_enc_pkg::*;
#(
    parameter int NUM_BLK = NUM_BLK_DEF,
    parameter int ADDR_W  = 5,
    parameter int ROM_LAT = 1,
    parameter int ENC_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_abort,
    output logic              o_rom_en,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic              o_enc_clr,
    output logic              o_enc_valid,
    output logic              o_enc_last,
    output logic              o_cw_valid,
    input  logic              i_cw_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_frame_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BLK - 1);
    localparam int                DRN_LOAD  = drain_load(ROM_LAT, ENC_LAT);
    localparam int                DRN_W     = $clog2(DRN_LOAD + 2);
    localparam logic [DRN_W-1:0]  DRN_INIT  = DRN_W'(DRN_LOAD);

    state_t            r_state, w_state_next;
    logic              r_rom_en, w_rom_en_next;
    logic [ADDR_W-1:0] r_rom_addr, w_rom_addr_next;
    logic              r_enc_clr, w_enc_clr_next;
    logic              r_cw_valid, w_cw_valid_next;
    logic              r_done, w_done_next;
    logic              r_busy;
    logic [CNT_W-1:0]  r_frame_cnt, w_frame_cnt_next;
    logic [DRN_W-1:0]  r_drn_cnt, w_drn_cnt_next;
    logic [1:0]        w_pipe_in, w_pipe_out;

`ifndef QC_ENC_CTRL_BP_EN
    logic w_unused_ready;
    assign w_unused_ready = i_cw_ready;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_rom_en    <= 1'b0;
            r_rom_addr  <= '0;
            r_enc_clr   <= 1'b0;
            r_cw_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
            r_drn_cnt   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_rom_en    <= w_rom_en_next;
            r_rom_addr  <= w_rom_addr_next;
            r_enc_clr   <= w_enc_clr_next;
            r_cw_valid  <= w_cw_valid_next;
            r_done      <= w_done_next;
            r_busy      <= (w_state_next != IDLE);
            r_frame_cnt <= w_frame_cnt_next;
            r_drn_cnt   <= w_drn_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_rom_en_next    = 1'b0;
        w_rom_addr_next  = '0;
        w_enc_clr_next   = 1'b0;
        w_cw_valid_next  = 1'b0;
        w_done_next      = 1'b0;
        w_frame_cnt_next = r_frame_cnt;
        w_drn_cnt_next   = r_drn_cnt;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_next   = FEED;
                    w_rom_en_next  = 1'b1;
                    w_enc_clr_next = 1'b1;
                end
            end
            FEED: begin
                if (r_rom_addr == LAST_ADDR) begin
                    w_state_next   = DRAIN;
                    w_drn_cnt_next = DRN_INIT;
                end else begin
                    w_rom_en_next   = 1'b1;
                    w_rom_addr_next = r_rom_addr + 1'b1;
                end
            end
            DRAIN: begin
                if (r_drn_cnt == '0) begin
                    w_state_next    = HOLD;
                    w_cw_valid_next = 1'b1;
`ifndef QC_ENC_CTRL_BP_EN
                    // Without backpressure the frame completes as cw_valid is raised.
                    w_done_next      = 1'b1;
                    w_frame_cnt_next = r_frame_cnt + 1'b1;
`endif
                end else begin
                    w_drn_cnt_next = r_drn_cnt - 1'b1;
                end
            end
            HOLD: begin
`ifdef QC_ENC_CTRL_BP_EN
                if (i_cw_ready) begin
                    w_state_next     = IDLE;
                    w_done_next      = 1'b1;
                    w_frame_cnt_next = r_frame_cnt + 1'b1;
                end else begin
                    w_cw_valid_next = 1'b1;
                end
`else
                w_state_next = IDLE;
`endif
            end
            default: w_state_next = IDLE;
        endcase
        // Abort overrides everything, including a start in the same cycle.
        if (i_abort) begin
            w_state_next     = IDLE;
            w_rom_en_next    = 1'b0;
            w_rom_addr_next  = '0;
            w_enc_clr_next   = 1'b0;
            w_cw_valid_next  = 1'b0;
            w_done_next      = 1'b0;
            w_frame_cnt_next = r_frame_cnt;
            w_drn_cnt_next   = '0;
        end
    end

    assign w_pipe_in = {r_rom_en, r_rom_en && (r_rom_addr == LAST_ADDR)};

    qc_lat_pipe #(
        .W     (2),
        .DEPTH (ROM_LAT)
    ) u_lat_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_flush (i_abort),
        .i_d     (w_pipe_in),
        .o_q     (w_pipe_out)
    );

    assign o_rom_en    = r_rom_en;
    assign o_rom_addr  = r_rom_addr;
    assign o_enc_clr   = r_enc_clr;
    assign o_enc_valid = w_pipe_out[1];
    assign o_enc_last  = w_pipe_out[0];
    assign o_cw_valid  = r_cw_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_qc_enc_ctrl.sv
// Scoreboard bench for qc_enc_ctrl: default instance plus a short-frame, long-latency instance.
module tb_qc_enc_ctrl;

    typedef struct {
        int first_rom;
        int first_valid;
        int nvalid;
        int last;
        int cw_rise;
        int cw_len;
        int done_cyc;
        int fcnt;
        int addr_err;
    } frame_t;

`ifdef QC_ENC_CTRL_BP_EN
    localparam int BP = 1;
`else
    localparam int BP = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start, i_abort, i_cw_ready;
    logic        o_rom_en, o_enc_clr, o_enc_valid, o_enc_last, o_cw_valid, o_busy, o_done;
    logic [4:0]  o_rom_addr;
    logic [15:0] o_frame_cnt;

    logic        i_start6, i_abort6, i_cw_ready6;
    logic        o_rom_en6, o_enc_clr6, o_enc_valid6, o_enc_last6, o_cw_valid6, o_busy6, o_done6;
    logic [4:0]  o_rom_addr6;
    logic [1:0]  o_frame_cnt6;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     ecnt    = 0;
    int     exp_fc  = 0;
    frame_t exp_q[$];
    frame_t obs_q[$];
    frame_t m_cur;
    int     m_idx;

    qc_enc_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_abort     (i_abort),
        .o_rom_en    (o_rom_en),
        .o_rom_addr  (o_rom_addr),
        .o_enc_clr   (o_enc_clr),
        .o_enc_valid (o_enc_valid),
        .o_enc_last  (o_enc_last),
        .o_cw_valid  (o_cw_valid),
        .i_cw_ready  (i_cw_ready),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_frame_cnt (o_frame_cnt)
    );

    qc_enc_ctrl #(
        .NUM_BLK (4),
        .ADDR_W  (5),
        .ROM_LAT (3),
        .ENC_LAT (2),
        .CNT_W   (2)
    ) u_dut6 (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start6),
        .i_abort     (i_abort6),
        .o_rom_en    (o_rom_en6),
        .o_rom_addr  (o_rom_addr6),
        .o_enc_clr   (o_enc_clr6),
        .o_enc_valid (o_enc_valid6),
        .o_enc_last  (o_enc_last6),
        .o_cw_valid  (o_cw_valid6),
        .i_cw_ready  (i_cw_ready6),
        .o_busy      (o_busy6),
        .o_done      (o_done6),
        .o_frame_cnt (o_frame_cnt6)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    // Monitor: builds one observed record per completed frame.
    always @(negedge clk) begin
        if (o_enc_clr) begin
            m_cur.first_rom   = ecnt;
            m_cur.first_valid = -1;
            m_cur.nvalid      = 0;
            m_cur.last        = -1;
            m_cur.cw_rise     = -1;
            m_cur.cw_len      = 0;
            m_cur.addr_err    = 0;
            m_idx             = 0;
        end
        if (o_rom_en) begin
            if (int'(o_rom_addr) != m_idx) m_cur.addr_err++;
            m_idx++;
        end else if (o_rom_addr != 5'd0) begin
            m_cur.addr_err++;
        end
        if (o_enc_valid) begin
            if (m_cur.nvalid == 0) m_cur.first_valid = ecnt;
            m_cur.nvalid++;
        end
        if (o_enc_last) m_cur.last = ecnt;
        if (o_cw_valid) begin
            if (m_cur.cw_len == 0) m_cur.cw_rise = ecnt;
            m_cur.cw_len++;
        end
        if (o_done) begin
            m_cur.done_cyc = ecnt;
            m_cur.fcnt     = int'(o_frame_cnt);
            obs_q.push_back(m_cur);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (ecnt < target) @(negedge clk);
    endtask

    function automatic frame_t exp_frame(input int s, input int hold, input int fc);
        frame_t f;
        f.first_rom   = s + 1;
        f.first_valid = s + 2;
        f.nvalid      = 18;
        f.last        = s + 19;
        f.cw_rise     = s + 20;
        f.cw_len      = 1 + BP * hold;
        f.done_cyc    = s + 20 + BP * (1 + hold);
        f.fcnt        = fc;
        f.addr_err    = 0;
        return f;
    endfunction

    task automatic check_frame(input string tag);
        frame_t o, e;
        int     k;
        k = 0;
        while (obs_q.size() == 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_arrived"}, (obs_q.size() > 0) ? 1 : 0, 1);
        if (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            $display("[TB] %s frame: rom@%0d valid@%0d x%0d last@%0d cw@%0d len%0d done@%0d cnt%0d",
                     tag, o.first_rom, o.first_valid, o.nvalid, o.last, o.cw_rise, o.cw_len,
                     o.done_cyc, o.fcnt);
            check({tag, "_first_rom"},   o.first_rom,   e.first_rom);
            check({tag, "_first_valid"}, o.first_valid, e.first_valid);
            check({tag, "_nvalid"},      o.nvalid,      e.nvalid);
            check({tag, "_last"},        o.last,        e.last);
            check({tag, "_cw_rise"},     o.cw_rise,     e.cw_rise);
            check({tag, "_cw_len"},      o.cw_len,      e.cw_len);
            check({tag, "_done_cyc"},    o.done_cyc,    e.done_cyc);
            check({tag, "_fcnt"},        o.fcnt,        e.fcnt);
            check({tag, "_addr_err"},    o.addr_err,    e.addr_err);
        end
    endtask

    initial begin
        int s;
        int k;
        rst         = 1'b0;
        i_start     = 1'b0;
        i_abort     = 1'b0;
        i_cw_ready  = 1'b1;
        i_start6    = 1'b0;
        i_abort6    = 1'b0;
        i_cw_ready6 = 1'b1;
        tick();
        tick();
        check("reset_outputs",
              {o_rom_en, o_rom_addr, o_enc_clr, o_enc_valid, o_enc_last, o_cw_valid, o_busy, o_done, o_frame_cnt}, 0);
        check("reset_outputs6",
              {o_rom_en6, o_rom_addr6, o_enc_clr6, o_enc_valid6, o_enc_last6, o_cw_valid6, o_busy6, o_done6, o_frame_cnt6}, 0);
        rst = 1'b1;
        tick();

        // 1: single frame, consumer always ready
        s = ecnt;
        i_start = 1'b1;
        exp_fc++;
        exp_q.push_back(exp_frame(s, 0, exp_fc));
        tick();
        i_start = 1'b0;
        check("t1_enc_clr", o_enc_clr, 1);
        check("t1_rom_en", o_rom_en, 1);
        check("t1_addr0", o_rom_addr, 0);
        check("t1_busy", o_busy, 1);
        tick();
        check("t1_enc_clr_pulse", o_enc_clr, 0);
        wait_cyc(s + 21);
        check("t1_busy21", o_busy, 0);
        check("t1_done21", o_done, BP);
        check("t1_fcnt21", o_frame_cnt, 1);
        check_frame("t1");

        // 2: consumer stalls 5 cycles after cw_valid
        tick();
        i_cw_ready = 1'b0;
        s = ecnt;
        i_start = 1'b1;
        exp_fc++;
        exp_q.push_back(exp_frame(s, 5, exp_fc));
        tick();
        i_start = 1'b0;
        k = 0;
        while (!o_cw_valid && k < 40) begin
            tick();
            k++;
        end
        check("t2_cw_seen", o_cw_valid, 1);
        repeat (5) tick();
        check("t2_cw_held", o_cw_valid, BP);
        i_cw_ready = 1'b1;
        check_frame("t2");
        repeat (5) tick();
        check("t2_single_done", obs_q.size(), 0);

        // 3: start held high, frames back-to-back
        s = ecnt;
        i_start = 1'b1;
        for (int f = 0; f < 3; f++) begin
            exp_fc++;
            exp_q.push_back(exp_frame(s + 21 * f, 0, exp_fc));
        end
        tick();
        check_frame("t3a");
        check_frame("t3b");
        wait_cyc(s + 45);
        i_start = 1'b0;
        check_frame("t3c");
        repeat (10) tick();
        check("t3_no_queue_busy", o_busy, 0);
        check("t3_no_queue_done", obs_q.size(), 0);

        // 4: abort mid-FEED, then abort+start together, then a clean frame
        s = ecnt;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_cyc(s + 10);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check("t4_enc_valid11", o_enc_valid, 0);
        check("t4_busy11", o_busy, 0);
        check("t4_rom_en11", o_rom_en, 0);
        check("t4_fcnt", o_frame_cnt, exp_fc);
        repeat (25) tick();
        check("t4_no_done", obs_q.size(), 0);
        check("t4_no_cw", o_cw_valid, 0);
        i_start = 1'b1;
        i_abort = 1'b1;
        tick();
        i_start = 1'b0;
        i_abort = 1'b0;
        check("t4_abort_beats_start", {o_busy, o_rom_en}, 0);
        tick();
        s = ecnt;
        i_start = 1'b1;
        exp_fc++;
        exp_q.push_back(exp_frame(s, 0, exp_fc));
        tick();
        i_start = 1'b0;
        check_frame("t4_after");

        // 5: asynchronous reset mid-FEED
        tick();
        s = ecnt;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_cyc(s + 6);
        check("t5_in_feed", o_rom_en, 1);
        rst = 1'b0;
        #1;
        check("t5_async_clear",
              {o_rom_en, o_rom_addr, o_enc_clr, o_enc_valid, o_enc_last, o_cw_valid, o_busy, o_done, o_frame_cnt}, 0);
        tick();
        tick();
        rst = 1'b1;
        exp_fc = 0;
        tick();
        s = ecnt;
        i_start = 1'b1;
        exp_fc++;
        exp_q.push_back(exp_frame(s, 0, exp_fc));
        tick();
        i_start = 1'b0;
        check_frame("t5_after");

        // 6: NUM_BLK=4, ROM_LAT=3, ENC_LAT=2, CNT_W=2
        tick();
        s = ecnt;
        i_start6 = 1'b1;
        tick();
        i_start6 = 1'b0;
        for (int j = 1; j <= 11; j++) begin
            check($sformatf("t6_cyc%0d", j),
                  {o_rom_en6, o_enc_valid6, o_enc_last6, o_cw_valid6},
                  {(j >= 1 && j <= 4), (j >= 4 && j <= 7), (j == 7), (j == 9)});
            tick();
        end
        check("t6_fcnt1", o_frame_cnt6, 1);
        for (int f = 0; f < 4; f++) begin
            i_start6 = 1'b1;
            tick();
            i_start6 = 1'b0;
            k = 0;
            while (o_busy6 && k < 40) begin
                tick();
                k++;
            end
            check($sformatf("t6_idle%0d", f), o_busy6, 0);
            check($sformatf("t6_wrap%0d", f), o_frame_cnt6, (2 + f) % 4);
        end

        check("end_exp_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
